// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, registered fill count and sticky overflow/underflow flags.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (rdata shows the head entry whenever rempty=0). When it is left undefined,
// rdata is a register loaded on each accepted read.
//
// Ports:
//   clk           - clock, all state updates on its rising edge
//   rst           - asynchronous active-high reset
//   wdata/winc    - write data and write request
//   rinc          - read request
//   err_clr       - clears the sticky overflow/underflow flags
//   rdata         - read data
//   wfull/rempty  - full / empty flags (registered)
//   walmost_full  - count >= AF_LEVEL (registered)
//   ralmost_empty - count <= AE_LEVEL (registered)
//   count         - fill level 0..2**ASIZE (registered)
//   overflow      - sticky: write attempted while full
//   underflow     - sticky: read attempted while empty
module sync_fifo_prog #(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned ASIZE    = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW    = ASIZE + 1;
  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_count;
  logic             r_wfull;
  logic             r_rempty;
  logic             r_walmost_full;
  logic             r_ralmost_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_en;
  logic             w_rd_en;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rptr_nxt;
  logic [PW-1:0]    w_count_nxt;
  logic             w_wfull_nxt;
  logic             w_rempty_nxt;
  logic             w_ovf_evt;
  logic             w_udf_evt;

  // Acceptance depends only on registered flags, so no winc/rinc -> flag path.
  assign w_wr_en   = winc & ~r_wfull;
  assign w_rd_en   = rinc & ~r_rempty;
  assign w_ovf_evt = winc & r_wfull;
  assign w_udf_evt = rinc & r_rempty;

  assign w_wptr_nxt  = r_wptr + PW'(w_wr_en);
  assign w_rptr_nxt  = r_rptr + PW'(w_rd_en);
  // Modular pointer difference yields 0..DEPTH thanks to the extra wrap bit.
  assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

  assign w_wfull_nxt  = (w_wptr_nxt[ASIZE] != w_rptr_nxt[ASIZE]) &&
                        (w_wptr_nxt[ASIZE-1:0] == w_rptr_nxt[ASIZE-1:0]);
  assign w_rempty_nxt = (w_wptr_nxt == w_rptr_nxt);

  // Storage array: deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_mem[r_wptr[ASIZE-1:0]] <= wdata;
    end
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_rempty        <= 1'b1;
      r_walmost_full  <= 1'b0;
      r_ralmost_empty <= 1'b1;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_wptr          <= w_wptr_nxt;
      r_rptr          <= w_rptr_nxt;
      r_count         <= w_count_nxt;
      r_wfull         <= w_wfull_nxt;
      r_rempty        <= w_rempty_nxt;
      r_walmost_full  <= (32'(w_count_nxt) >= AF_LEVEL);
      r_ralmost_empty <= (32'(w_count_nxt) <= AE_LEVEL);
      // A new error on the clearing edge keeps the flag set.
      r_overflow      <= w_ovf_evt | (r_overflow  & ~err_clr);
      r_underflow     <= w_udf_evt | (r_underflow & ~err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible whenever the FIFO holds data; zero when empty.
  assign rdata = r_rempty ? '0 : r_mem[r_rptr[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] r_rdata;

  // Read data register, loaded only on an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
    end
  end

  assign rdata = r_rdata;
`endif

  assign wfull         = r_wfull;
  assign rempty        = r_rempty;
  assign walmost_full  = r_walmost_full;
  assign ralmost_empty = r_ralmost_empty;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data width in bits.
REQ-002 SHALL have parameter ASIZE, default 4: address width, so depth = 2**ASIZE entries.
REQ-003 SHALL have parameter AF_LEVEL, default 14: count at or above which walmost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2: count at or below which ralmost_empty asserts.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port wdata, input, DSIZE bits: write data.
REQ-008 SHALL have port winc, input, 1 bit: write request.
REQ-009 SHALL have port rinc, input, 1 bit: read request.
REQ-010 SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-011 SHALL have port rdata, output, DSIZE bits: read data.
REQ-012 SHALL have port wfull, output, 1 bit: FIFO full.
REQ-013 SHALL have port rempty, output, 1 bit: FIFO empty.
REQ-014 SHALL have port walmost_full, output, 1 bit: count >= AF_LEVEL.
REQ-015 SHALL have port ralmost_empty, output, 1 bit: count <= AE_LEVEL.
REQ-016 SHALL have port count, output, ASIZE+1 bits: current fill level, 0 to 2**ASIZE.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag for a rejected write.
REQ-018 SHALL have port underflow, output, 1 bit: sticky flag for a rejected read.

Function
REQ-019 Write accepted iff winc=1 and wfull=0 at the edge; data stored at waddr, write pointer increments.
REQ-020 Read accepted iff rinc=1 and rempty=0 at the edge; read pointer increments.
REQ-021 Pointers SHALL be ASIZE+1-bit binary and wrap from 2**(ASIZE+1)-1 to 0; address = low ASIZE bits.
REQ-022 Full: pointer MSBs differ and low bits equal. Empty: pointers equal.
REQ-023 count, wfull, rempty, walmost_full and ralmost_empty SHALL be registered and reflect state after each edge, with no combinational path from winc or rinc.
REQ-024 Write and read in the same cycle, neither full nor empty: both accepted, count unchanged.
REQ-025 When full, a simultaneous winc+rinc: read accepted, write rejected, overflow set, count decrements by 1.
REQ-026 When empty, a simultaneous winc+rinc: write accepted, read rejected, underflow set, count increments by 1.
REQ-027 Write-to-not-empty latency: rempty deasserts after the same edge that accepts the first write.
REQ-028 overflow/underflow SHALL stay set until err_clr=1 at an edge; a new error on the same edge as err_clr wins (flag stays set).
REQ-029 A rejected access SHALL change neither memory, pointers nor count.

Reset
REQ-030 While rst=1, asynchronously: pointers=0, count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, overflow=0, underflow=0, rdata=0.
REQ-031 Memory contents SHALL NOT be reset; rst asserted mid-operation discards all stored entries.
REQ-032 First accepted access SHALL be on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; rdata shows the head entry whenever rempty=0 (valid on the same edge rempty falls), and rinc consumes it.
REQ-034 Macro SYNC_FIFO_FWFT_EN undefined: standard mode; rdata is a register loaded with the head entry on an accepted read (one-cycle latency) and holds its value otherwise.
REQ-035 Flags, count and error behaviour SHALL be identical in both modes.

Verification (DSIZE=8, ASIZE=4, AF=14, AE=2)
REQ-036 Reset, then write 0x01..0x10 -> wfull=1 and count=16 after the 16th write, walmost_full=1 from count=14, ralmost_empty=0 from count=3.
REQ-037 Full, winc with 0xAA -> overflow=1, count stays 16; then err_clr pulse -> overflow=0.
REQ-038 Drain 16 reads -> data 0x01..0x10 in order (standard: one cycle after each rinc; FWFT: presented before each rinc), rempty=1 at end; one further rinc -> underflow=1.
REQ-039 Fill to 8, then simultaneous winc+rinc for 40 cycles -> count stays 8, pointers wrap, data order preserved.
REQ-040 Full, winc+rinc together -> read returns the oldest entry, write rejected, count=15, overflow=1; empty, winc+rinc with 0x55 -> count=1, underflow=1.
REQ-041 Fill to 5, assert rst asynchronously mid-cycle -> all outputs at reset values before the next edge; a subsequent write of 0x77 reads back 0x77.
